// File: rtl/blackparrot_fpga_nbf_loader_pkg.sv
// Shared NBF loader types: command layout, opcodes and loader FSM states.
package bp_fpga_host_pkg;

  localparam int nbf_flits_lp = 5;

  typedef enum logic [7:0] {
    e_nbf_wr_1b  = 8'h00,
    e_nbf_wr_2b  = 8'h01,
    e_nbf_wr_4b  = 8'h02,
    e_nbf_wr_8b  = 8'h03,
    e_nbf_fence  = 8'hFE,
    e_nbf_finish = 8'hFF
  } nbf_opcode_e;

  // Opcode is kept as raw bits so unknown values can be seen and rejected.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [63:0] addr;
    logic [63:0] data;
  } nbf_cmd_s;

  typedef enum logic [1:0] {
    e_collect,
    e_send,
    e_fence,
    e_done
  } nbf_loader_state_e;

endpackage

// File: rtl/blackparrot_fpga_nbf_loader_counter.sv
// Saturating up/down counter; simultaneous up and down leaves the count unchanged.
module bsg_counter_up_down #(
  parameter int max_val_p = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           up_i,
  input  logic                           down_i,
  output logic [$clog2(max_val_p+1)-1:0] count_o
);

  localparam int width_lp = $clog2(max_val_p + 1);

  logic [width_lp-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (up_i && !down_i && (r_count != width_lp'(max_val_p))) begin
      r_count <= r_count + 1'b1;
    end else if (down_i && !up_i && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/blackparrot_fpga_nbf_loader.sv
// Assembles 5-flit NBF commands from the host and issues them as I/O writes,
// honouring fence/finish by waiting for all outstanding write responses.
module blackparrot_fpga_nbf_loader
  import bp_fpga_host_pkg::*;
#(
  parameter int S_AXIL_DATA_WIDTH  = 32,
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 64,
  parameter int nbf_data_width_p   = 64,
  parameter int max_outstanding_p  = 8,
  localparam int out_width_lp      = $clog2(max_outstanding_p + 1)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [S_AXIL_DATA_WIDTH-1:0]  flit_i,
  input  logic                          flit_v_i,
  output logic                          flit_ready_o,
  output logic [nbf_addr_width_p-1:0]   io_addr_o,
  output logic [nbf_data_width_p-1:0]   io_data_o,
  output logic [1:0]                    io_size_o,
  output logic                          io_v_o,
  input  logic                          io_ready_i,
  input  logic                          io_resp_v_i,
  output logic [out_width_lp-1:0]       outstanding_o,
  output logic                          done_o,
  output logic                          err_o
);

  nbf_loader_state_e              r_state, w_state_next;
  logic [2:0]                     r_flit_cnt;
  logic [S_AXIL_DATA_WIDTH-1:0]   r_asm_flit [nbf_flits_lp-1];
  nbf_cmd_s                       r_cmd;
  logic                           r_finish;
  logic                           r_err;
  logic                           r_run;

  logic [nbf_opcode_width_p-1:0]  w_op;
  logic                           w_flit_acc, w_last;
  logic                           w_is_wr, w_is_fence, w_is_finish, w_unknown;
  logic                           w_hs, w_spurious;
  logic [out_width_lp-1:0]        w_count;

  assign w_op        = flit_i[nbf_opcode_width_p-1:0];
  assign w_is_wr     = (w_op[nbf_opcode_width_p-1:2] == '0);
  assign w_is_fence  = (w_op == nbf_opcode_width_p'(e_nbf_fence));
  assign w_is_finish = (w_op == nbf_opcode_width_p'(e_nbf_finish));
  assign w_unknown   = !(w_is_wr || w_is_fence || w_is_finish);
  assign w_flit_acc  = flit_v_i && flit_ready_o;
  assign w_last      = w_flit_acc && (r_flit_cnt == 3'(nbf_flits_lp - 1));
  assign w_hs        = io_v_o && io_ready_i;
  assign w_spurious  = io_resp_v_i && (w_count == '0);

  bsg_counter_up_down #(
    .max_val_p (max_outstanding_p)
  ) u_outstanding (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .up_i    (w_hs),
    .down_i  (io_resp_v_i),
    .count_o (w_count)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= e_collect;
    else          r_state <= w_state_next;
  end

  // io_v_o cannot drop once raised: the count only rises on our own handshake.
  always_comb begin
    w_state_next = r_state;
    flit_ready_o = 1'b0;
    io_v_o       = 1'b0;
    case (r_state)
      e_collect: begin
        flit_ready_o = r_run;
        if (w_last) begin
          if (w_is_wr)                        w_state_next = e_send;
          else if (w_is_fence || w_is_finish) w_state_next = e_fence;
        end
      end
      e_send: begin
        io_v_o = (w_count < out_width_lp'(max_outstanding_p));
        if (io_v_o && io_ready_i) w_state_next = e_collect;
      end
      e_fence: begin
        if (w_count == '0) w_state_next = r_finish ? e_done : e_collect;
      end
      e_done:  w_state_next = e_done;
      default: w_state_next = e_collect;
    endcase
  end

  for (genvar gi = 0; gi < nbf_flits_lp - 1; gi++) begin : g_asm
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                                 r_asm_flit[gi] <= '0;
      else if (w_flit_acc && (r_flit_cnt == 3'(gi))) r_asm_flit[gi] <= flit_i;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_flit_cnt <= '0;
      r_cmd      <= '0;
      r_finish   <= 1'b0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_flit_acc) begin
        r_flit_cnt <= w_last ? 3'd0 : r_flit_cnt + 3'd1;
      end
      if (w_last && w_is_wr) begin
        r_cmd.opcode <= 8'(w_op);
        r_cmd.addr   <= {r_asm_flit[3], r_asm_flit[2]};
        r_cmd.data   <= {r_asm_flit[1], r_asm_flit[0]};
      end
      if (w_last && w_is_finish) r_finish <= 1'b1;
      if ((w_last && w_unknown) || w_spurious) r_err <= 1'b1;
    end
  end

  assign io_addr_o     = r_cmd.addr;
  assign io_data_o     = r_cmd.data;
  assign io_size_o     = r_cmd.opcode[1:0];
  assign outstanding_o = w_count;
  assign done_o        = (r_state == e_done);
  assign err_o         = r_err;

endmodule

// File: tb/tb_blackparrot_fpga_nbf_loader.sv
// Randomized bench for the NBF loader, checked against a queue-based write/credit model.
module tb_blackparrot_fpga_nbf_loader;

  localparam int MAXO = 8;
  localparam int CW   = $clog2(MAXO + 1);

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } wr_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   flit_i = '0;
  logic          flit_v_i = 1'b0;
  logic          flit_ready_o;
  logic [63:0]   io_addr_o;
  logic [63:0]   io_data_o;
  logic [1:0]    io_size_o;
  logic          io_v_o;
  logic          io_ready_i = 1'b0;
  logic          io_resp_v_i = 1'b0;
  logic [CW-1:0] outstanding_o;
  logic          done_o;
  logic          err_o;

  blackparrot_fpga_nbf_loader #(
    .max_outstanding_p (MAXO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .flit_i        (flit_i),
    .flit_v_i      (flit_v_i),
    .flit_ready_o  (flit_ready_o),
    .io_addr_o     (io_addr_o),
    .io_data_o     (io_data_o),
    .io_size_o     (io_size_o),
    .io_v_o        (io_v_o),
    .io_ready_i    (io_ready_i),
    .io_resp_v_i   (io_resp_v_i),
    .outstanding_o (outstanding_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 aclk = ~aclk;

  int  n_checks = 0;
  int  n_pass   = 0;

  // reference model state
  wr_t exp_q[$];
  int  resp_due[$];
  int  m_out = 0;
  bit  m_err = 1'b0;
  int  hs_count = 0;
  int  cyc = 0;
  bit  mon_hs;
  int  ready_pct = 100;
  int  dmin = 1;
  int  dmax = 4;
  bit  resp_hold = 1'b0;
  int  resp_req = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // downstream ready and write-response generator
  always @(negedge aclk) begin
    io_ready_i  = ($urandom_range(0, 99) < ready_pct);
    io_resp_v_i = 1'b0;
    if (resp_req > 0) begin
      io_resp_v_i = 1'b1;
      resp_req--;
    end else if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
      io_resp_v_i = 1'b1;
      void'(resp_due.pop_front());
    end
  end

  // per-cycle monitor: compare DUT against model, then advance model
  always @(negedge aclk) begin
    #1;
    cyc++;
    if (!aresetn) begin
      m_out = 0;
      m_err = 1'b0;
      exp_q.delete();
      resp_due.delete();
    end else begin
      check("outstanding", 64'(outstanding_o), 64'(m_out));
      check("err", 64'(err_o), 64'(m_err));
      if (io_v_o) begin
        check("credit", 64'(m_out < MAXO), 64'd1);
        if (exp_q.size() == 0) begin
          check("io_v_unexpected", 64'(io_v_o), 64'd0);
        end else begin
          check("io_addr", io_addr_o, exp_q[0].addr);
          check("io_data", io_data_o, exp_q[0].data);
          check("io_size", 64'(io_size_o), 64'(exp_q[0].size));
        end
      end
      mon_hs = io_v_o && io_ready_i;
      if (mon_hs) begin
        $display("write addr=%h data=%h size=%0d", io_addr_o, io_data_o, io_size_o);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs_count++;
        if (!resp_hold) resp_due.push_back(cyc + $urandom_range(dmin, dmax));
      end
      if (io_resp_v_i && m_out == 0) m_err = 1'b1;
      if (mon_hs && !io_resp_v_i)                   m_out++;
      else if (!mon_hs && io_resp_v_i && m_out > 0) m_out--;
    end
  end

  task automatic send_flit(input logic [31:0] f, output bit ok);
    int t = 0;
    @(negedge aclk);
    flit_v_i = 1'b1;
    flit_i   = f;
    #1;
    while (!flit_ready_o && t < 400) begin
      @(negedge aclk);
      #1;
      t++;
    end
    ok = flit_ready_o;
    @(negedge aclk);
    flit_v_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [63:0] addr, input logic [63:0] data);
    logic [31:0] fl [5];
    bit ok;
    wr_t w;
    fl[0] = data[31:0];
    fl[1] = data[63:32];
    fl[2] = addr[31:0];
    fl[3] = addr[63:32];
    fl[4] = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom), op};
    for (int i = 0; i < 5; i++) begin
      send_flit(fl[i], ok);
      if (!ok) check("flit_timeout", 64'd0, 64'd1);
    end
    $display("cmd op=%h addr=%h data=%h", op, addr, data);
    if (op[7:2] == 6'd0) begin
      w.addr = addr; w.data = data; w.size = op[1:0];
      exp_q.push_back(w);
    end else if (op != 8'hFE && op != 8'hFF) begin
      m_err = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((outstanding_o != 0 || exp_q.size() != 0 || io_v_o) && t < 600) begin
      @(negedge aclk);
      #1;
      t++;
    end
    check(tag, 64'(outstanding_o == 0 && exp_q.size() == 0), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    flit_v_i = 1'b0;
    aresetn  = 1'b0;
    resp_req = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  initial begin
    bit ok;
    int t;
    int base;
    int nwr;
    logic [7:0] op;

    repeat (3) @(negedge aclk);
    #1;
    check("rst_flit_ready", 64'(flit_ready_o), 64'd0);
    check("rst_io_v", 64'(io_v_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_addr", io_addr_o, 64'd0);
    check("rst_data", io_data_o, 64'd0);
    check("rst_size", 64'(io_size_o), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // directed first write and its latency
    send_cmd(8'h03, 64'h0000_0000_8000_1000, 64'h5566_7788_1122_3344);
    #1;
    check("lat_io_v", 64'(io_v_o), 64'd1);
    check("lat_addr", io_addr_o, 64'h8000_1000);
    check("lat_data", io_data_o, 64'h5566_7788_1122_3344);
    check("lat_size", 64'(io_size_o), 64'd3);
    check("lat_ready_low", 64'(flit_ready_o), 64'd0);
    @(negedge aclk);
    #1;
    check("lat_out_one", 64'(outstanding_o), 64'd1);
    wait_idle("lat_idle");

    // random mix of writes and fences under backpressure
    ready_pct = 60; dmin = 1; dmax = 8;
    base = hs_count; nwr = 0;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 9) == 0) op = 8'hFE;
      else begin op = 8'($urandom_range(0, 3)); nwr++; end
      send_cmd(op, {$urandom, $urandom}, {$urandom, $urandom});
    end
    wait_idle("rand_idle");
    check("rand_hs_count", 64'(hs_count - base), 64'(nwr));

    // credit limit: nine writes with responses withheld
    ready_pct = 100; resp_hold = 1'b1;
    base = hs_count;
    for (int i = 0; i < 9; i++) send_cmd(8'h03, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (4) @(negedge aclk);
    #1;
    check("credit_hs8", 64'(hs_count - base), 64'd8);
    check("credit_stall_v", 64'(io_v_o), 64'd0);
    check("credit_out8", 64'(outstanding_o), 64'd8);
    resp_req = 1;
    @(negedge aclk);
    @(negedge aclk);
    #1;
    check("credit_release_v", 64'(io_v_o), 64'd1);
    @(negedge aclk);
    #1;
    check("credit_hs9", 64'(hs_count - base), 64'd9);
    resp_hold = 1'b0;
    resp_req  = 8;
    wait_idle("credit_idle");

    // fence with slow responses
    dmin = 20; dmax = 20;
    send_cmd(8'h02, {$urandom, $urandom}, {$urandom, $urandom});
    send_cmd(8'h01, {$urandom, $urandom}, {$urandom, $urandom});
    send_cmd(8'hFE, 64'd0, 64'd0);
    #1;
    check("fence_ready_low", 64'(flit_ready_o), 64'd0);
    t = 0;
    while (!flit_ready_o && t < 300) begin
      @(negedge aclk);
      #1;
      t++;
    end
    check("fence_release", 64'(flit_ready_o), 64'd1);
    check("fence_drained", 64'(outstanding_o), 64'd0);
    check("fence_waited", 64'(t >= 8), 64'd1);
    send_cmd(8'h00, {$urandom, $urandom}, {$urandom, $urandom});
    wait_idle("fence_idle");
    dmin = 1; dmax = 4;

    // unknown opcode, then a normal write
    send_cmd(8'h42, {$urandom, $urandom}, {$urandom, $urandom});
    #1;
    check("unk_err", 64'(err_o), 64'd1);
    check("unk_no_v", 64'(io_v_o), 64'd0);
    check("unk_ready", 64'(flit_ready_o), 64'd1);
    send_cmd(8'h03, {$urandom, $urandom}, {$urandom, $urandom});
    wait_idle("unk_next_idle");

    // spurious response at zero outstanding
    do_reset();
    #1;
    check("spur_pre_err", 64'(err_o), 64'd0);
    resp_req = 1;
    @(negedge aclk);
    @(negedge aclk);
    #1;
    check("spur_err", 64'(err_o), 64'd1);
    check("spur_out0", 64'(outstanding_o), 64'd0);

    // finish with one write outstanding
    do_reset();
    resp_hold = 1'b1;
    base = hs_count;
    send_cmd(8'h03, {$urandom, $urandom}, {$urandom, $urandom});
    send_cmd(8'hFF, 64'd0, 64'd0);
    repeat (5) @(negedge aclk);
    #1;
    check("fin_hs", 64'(hs_count - base), 64'd1);
    check("fin_done_wait", 64'(done_o), 64'd0);
    check("fin_ready_wait", 64'(flit_ready_o), 64'd0);
    resp_req = 1;
    t = 0;
    while (!done_o && t < 20) begin
      @(negedge aclk);
      #1;
      t++;
    end
    check("fin_done", 64'(done_o), 64'd1);
    check("fin_out0", 64'(outstanding_o), 64'd0);
    flit_v_i = 1'b1;
    flit_i   = $urandom;
    repeat (5) @(negedge aclk);
    #1;
    check("fin_ready_stuck", 64'(flit_ready_o), 64'd0);
    check("fin_no_v", 64'(io_v_o), 64'd0);
    check("fin_done_sticky", 64'(done_o), 64'd1);
    flit_v_i  = 1'b0;
    resp_hold = 1'b0;

    // reset in the middle of a command
    do_reset();
    send_cmd(8'h42, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++) send_flit($urandom, ok);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("mid_rst_ready", 64'(flit_ready_o), 64'd0);
    check("mid_rst_v", 64'(io_v_o), 64'd0);
    check("mid_rst_err", 64'(err_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    check("mid_rst_out", 64'(outstanding_o), 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    send_cmd(8'h02, 64'h0000_0001_0000_0040, 64'hDEAD_BEEF_CAFE_F00D);
    #1;
    check("post_rst_v", 64'(io_v_o), 64'd1);
    check("post_rst_addr", io_addr_o, 64'h0000_0001_0000_0040);
    check("post_rst_size", 64'(io_size_o), 64'd2);
    wait_idle("post_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
